// File: rtl/bus_write_arbiter.sv
// Round-robin arbiter that shares one register-file write bus between M requesters.
// Latency: a request seen in IDLE at edge k drives bus_en in cycles k+1..k+2; ack pulses in k+3.
// Backpressure: requesters hold req until ack; at most one write is in flight every 4 cycles.
module bus_write_arbiter #(
  parameter int M        = 4,
  parameter int N        = 8,
  parameter int B        = $clog2(N),
  parameter int WORDSIZE = 16,
  parameter int MI       = $clog2(M)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [M-1:0]          req,
  input  logic [M*B-1:0]        req_addr,
  input  logic [M*WORDSIZE-1:0] req_data,
  output logic [M-1:0]          ack,
  output logic                  busy,
  output logic [MI-1:0]         grant_id,
  output logic                  bus_en,
  output logic [B-1:0]          bus_addr,
  output logic [WORDSIZE-1:0]   bus_dout
);

  // LAUNCH and STROBE are the two EN-high cycles the decoder needs;
  // RELEASE drops EN and reports completion.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LAUNCH  = 2'd1,
    ST_STROBE  = 2'd2,
    ST_RELEASE = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [MI-1:0]         last_q, last_d;
  logic [MI-1:0]         gid_q, gid_d;
  logic [B-1:0]          addr_q, addr_d;
  logic [WORDSIZE-1:0]   dout_q, dout_d;

  // Arbitration signals (only consumed in IDLE).
  logic [M-1:0]          hi_mask;
  logic [M-1:0]          req_hi;
  logic                  win_vld;
  logic [MI-1:0]         win_idx;
  logic [B-1:0]          win_addr;
  logic [WORDSIZE-1:0]   win_data;

  // Lowest-index set bit of a request vector.
  function automatic logic [MI-1:0] first_set(input logic [M-1:0] v);
    logic [MI-1:0] idx;
    idx = '0;
    for (int i = M - 1; i >= 0; i--) begin
      if (v[i]) idx = MI'(i);
    end
    return idx;
  endfunction

  // Round-robin pick: prefer requesters above the last served one, else wrap to the lowest.
  always_comb begin
    hi_mask = '0;
    for (int i = 0; i < M; i++) begin
      hi_mask[i] = (MI'(i) > last_q);
    end
    req_hi  = req & hi_mask;
    win_vld = |req;
    win_idx = (|req_hi) ? first_set(req_hi) : first_set(req);
  end

  // Select the winner's address and data word from the packed request buses.
  always_comb begin
    win_addr = '0;
    win_data = '0;
    for (int i = 0; i < M; i++) begin
      if (MI'(i) == win_idx) begin
        win_addr = req_addr[i*B +: B];
        win_data = req_data[i*WORDSIZE +: WORDSIZE];
      end
    end
  end

  // Next-state logic: latch the grant in IDLE, then walk the fixed EN sequence.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    gid_d   = gid_q;
    addr_d  = addr_q;
    dout_d  = dout_q;
    case (state_q)
      ST_IDLE: begin
        if (win_vld) begin
          gid_d   = win_idx;
          addr_d  = win_addr;
          dout_d  = win_data;
          state_d = ST_LAUNCH;
        end
      end
      ST_LAUNCH:  state_d = ST_STROBE;
      ST_STROBE:  state_d = ST_RELEASE;
      ST_RELEASE: begin
        // The served requester drops to lowest priority for the next pick.
        last_d  = gid_q;
        state_d = ST_IDLE;
      end
      default:    state_d = ST_IDLE;
    endcase
  end

  // State registers; reset aborts any transfer and gives requester 0 first priority.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      last_q  <= MI'(M - 1);
      gid_q   <= '0;
      addr_q  <= '0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      gid_q   <= gid_d;
      addr_q  <= addr_d;
      dout_q  <= dout_d;
    end
  end

  // Outputs decode registered state only, so req never reaches an output combinationally.
  always_comb begin
    busy     = (state_q != ST_IDLE);
    bus_en   = (state_q == ST_LAUNCH) || (state_q == ST_STROBE);
    grant_id = gid_q;
    bus_addr = addr_q;
    bus_dout = dout_q;
    ack      = '0;
    for (int i = 0; i < M; i++) begin
      ack[i] = (state_q == ST_RELEASE) && (gid_q == MI'(i));
    end
  end

endmodule

// File: tb/tb_bus_write_arbiter.sv
// Directed bench for bus_write_arbiter with a transaction-level reference model.
// Latency: model tracks cycles-since-grant; outputs are compared every negedge.
// Backpressure: stimulus holds or drops req per scenario; no waits on DUT events.
module tb_bus_write_arbiter;

  localparam int M  = 4;
  localparam int N  = 8;
  localparam int B  = 3;
  localparam int W  = 16;
  localparam int MI = 2;

  logic              clk;
  logic              reset;
  logic [M-1:0]      req;
  logic [M*B-1:0]    req_addr;
  logic [M*W-1:0]    req_data;
  logic [M-1:0]      ack;
  logic              busy;
  logic [MI-1:0]     grant_id;
  logic              bus_en;
  logic [B-1:0]      bus_addr;
  logic [W-1:0]      bus_dout;

  int n_checks = 0;
  int n_fail   = 0;

  bus_write_arbiter #(.M(M), .N(N), .B(B), .WORDSIZE(W), .MI(MI)) dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .req_addr (req_addr),
    .req_data (req_data),
    .ack      (ack),
    .busy     (busy),
    .grant_id (grant_id),
    .bus_en   (bus_en),
    .bus_addr (bus_addr),
    .bus_dout (bus_dout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a write is a transaction that lasts three cycles after its grant.
  bit           m_busy;
  int           m_ph;
  int           m_last;
  int           m_gid;
  logic [B-1:0] m_addr;
  logic [W-1:0] m_data;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_busy = 1'b0; m_ph = 0; m_last = M - 1; m_gid = 0; m_addr = '0; m_data = '0;
    end else if (m_busy) begin
      if (m_ph == 3) begin
        m_busy = 1'b0; m_ph = 0; m_last = m_gid;
      end else begin
        m_ph++;
      end
    end else if (|req) begin
      int found;
      found = -1;
      for (int k = 1; k <= M; k++) begin
        int j;
        j = (m_last + k) % M;
        if (found < 0 && req[j]) found = j;
      end
      m_gid  = found;
      m_addr = req_addr[found*B +: B];
      m_data = req_data[found*W +: W];
      m_busy = 1'b1;
      m_ph   = 1;
    end
  end

  // Per-cycle comparison against the model plus bus invariants.
  int           en_run;
  logic         prev_busy;
  logic [B-1:0] prev_addr;
  logic [W-1:0] prev_dout;

  initial begin
    en_run = 0; prev_busy = 1'b0; prev_addr = '0; prev_dout = '0;
    repeat (2) @(negedge clk);
    forever begin
      int exp_ack;
      @(negedge clk);
      exp_ack = (m_busy && m_ph == 3) ? (1 << m_gid) : 0;
      check("model_busy",     32'(busy),     32'(m_busy));
      check("model_bus_en",   32'(bus_en),   32'(m_busy && m_ph < 3));
      check("model_ack",      32'(ack),      32'(exp_ack));
      check("model_grant_id", 32'(grant_id), 32'(m_gid));
      check("model_bus_addr", 32'(bus_addr), 32'(m_addr));
      check("model_bus_dout", 32'(bus_dout), 32'(m_data));
      check("ack_onehot0",    32'($onehot0(ack)), 32'd1);
      en_run = bus_en ? en_run + 1 : 0;
      check("en_run_le2",     32'(en_run <= 2), 32'd1);
      if (busy && prev_busy) begin
        check("addr_stable", 32'(bus_addr), 32'(prev_addr));
        check("dout_stable", 32'(bus_dout), 32'(prev_dout));
      end
      prev_busy = busy; prev_addr = bus_addr; prev_dout = bus_dout;
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic set_src(input int i, input logic [B-1:0] a, input logic [W-1:0] d);
    req_addr[i*B +: B] = a;
    req_data[i*W +: W] = d;
  endtask

  int grants[$];
  int ack_cyc[$];
  int exp_order[8] = '{0, 1, 2, 3, 0, 1, 2, 3};

  initial begin
    reset = 1'b1; req = '0; req_addr = '0; req_data = '0;
    repeat (3) tick();
    check("rst_busy",  32'(busy),     32'd0);
    check("rst_en",    32'(bus_en),   32'd0);
    check("rst_ack",   32'(ack),      32'd0);
    check("rst_addr",  32'(bus_addr), 32'd0);
    check("rst_dout",  32'(bus_dout), 32'd0);
    check("rst_gid",   32'(grant_id), 32'd0);
    reset = 1'b0;

    // Single write from requester 0.
    tick();
    set_src(0, 3'd3, 16'hA5A5);
    req = 4'b0001;
    check("t1_en_c0", 32'(bus_en), 32'd0);
    tick();
    check("t1_en_c1", 32'(bus_en), 32'd1);
    check("t1_addr",  32'(bus_addr), 32'd3);
    check("t1_dout",  32'(bus_dout), 32'hA5A5);
    check("t1_ack_c1", 32'(ack), 32'd0);
    tick();
    check("t1_en_c2", 32'(bus_en), 32'd1);
    tick();
    check("t1_en_c3", 32'(bus_en), 32'd0);
    check("t1_ack_c3", 32'(ack), 32'b0001);
    req = 4'b0000;
    tick();
    check("t1_ack_c4", 32'(ack), 32'd0);
    check("t1_busy_c4", 32'(busy), 32'd0);

    // All four requesters held: grant order 0,1,2,3,0,... with one ack per 4 cycles.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < M; i++) set_src(i, 3'(7 - i), 16'(16'h1000 * (i + 1) + i));
    req = 4'b1111;
    for (int c = 1; c <= 31; c++) begin
      tick();
      for (int i = 0; i < M; i++) begin
        if (ack[i]) begin
          grants.push_back(i);
          ack_cyc.push_back(c);
        end
      end
      if (c == 31) req = 4'b0000;
    end
    check("t2_num_acks", 32'(grants.size()), 32'd8);
    for (int n = 0; n < grants.size() && n < 8; n++) begin
      check("t2_grant_order", 32'(grants[n]), 32'(exp_order[n]));
      check("t2_ack_cycle",   32'(ack_cyc[n]), 32'(4 * n + 3));
    end

    // Establish last=1, then req1+req3: req3 wins, and a late req_data1 change shows only in req1's write.
    tick();
    req = 4'b0010;
    repeat (3) tick();
    check("t3_pre_ack", 32'(ack), 32'b0010);
    req = 4'b0000;
    tick();
    set_src(1, 3'd1, 16'h1111);
    set_src(3, 3'd6, 16'h3333);
    req = 4'b1010;
    tick();
    check("t3_first_gid",  32'(grant_id), 32'd3);
    check("t3_first_dout", 32'(bus_dout), 32'h3333);
    set_src(1, 3'd2, 16'hBEEF);
    repeat (2) tick();
    check("t3_first_ack", 32'(ack), 32'b1000);
    check("t3_dout_held", 32'(bus_dout), 32'h3333);
    req = 4'b0010;
    repeat (2) tick();
    check("t3_second_gid",  32'(grant_id), 32'd1);
    check("t3_second_dout", 32'(bus_dout), 32'hBEEF);
    check("t3_second_addr", 32'(bus_addr), 32'd2);
    repeat (2) tick();
    check("t3_second_ack", 32'(ack), 32'b0010);
    req = 4'b0000;
    tick();

    // Reset during STROBE aborts without ack; the held request is re-granted afterwards.
    set_src(2, 3'd5, 16'h2222);
    req = 4'b0100;
    repeat (2) tick();
    check("t4_strobe_en", 32'(bus_en), 32'd1);
    #3 reset = 1'b1;
    #1;
    check("t4_rst_en",   32'(bus_en), 32'd0);
    check("t4_rst_busy", 32'(busy),   32'd0);
    check("t4_rst_ack",  32'(ack),    32'd0);
    tick();
    reset = 1'b0;
    tick();
    check("t4_regrant_gid", 32'(grant_id), 32'd2);
    check("t4_regrant_en",  32'(bus_en),   32'd1);
    repeat (2) tick();
    check("t4_ack", 32'(ack), 32'b0100);
    req = 4'b0000;
    tick();

    // One-cycle req pulse still runs the full write and acks once.
    req = 4'b0100;
    tick();
    req = 4'b0000;
    check("t5_en_c1", 32'(bus_en), 32'd1);
    repeat (2) tick();
    check("t5_ack", 32'(ack), 32'b0100);
    tick();
    check("t5_idle_en",   32'(bus_en), 32'd0);
    check("t5_idle_busy", 32'(busy),   32'd0);
    check("t5_idle_ack",  32'(ack),    32'd0);
    tick();
    check("t5_no_regrant", 32'(busy), 32'd0);

    repeat (2) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
